// File: rtl/memory_game_core_pkg.sv
// Shared types and LFSR constants for the memory game round engine.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW_ON,
        ST_SHOW_GAP,
        ST_INPUT,
        ST_WIN,
        ST_LOSE
    } game_state_e;

    localparam int          LFSR_W        = 16;
    // Taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] ZERO_SEED_SUB = 16'h0001;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? ZERO_SEED_SUB : s;
    endfunction

endpackage

// File: rtl/memory_game_core_if.sv
// Bundle between key/switch front end, the round engine and the LED/HEX drivers.
interface memory_game_core_if #(
    parameter int N_LEDS     = 4,
    parameter int MAX_ROUNDS = 16
);
    import game_pkg::*;

    localparam int RND_W = $clog2(MAX_ROUNDS + 1);

    // start and key_pulse are single-cycle strobes with no back-pressure:
    // the core samples them on every rising edge and acts only in the states
    // that accept them; every output is a registered level or one-cycle pulse.
    logic                start;
    logic [15:0]         seed;
    logic [N_LEDS-1:0]   key_pulse;
    logic [N_LEDS-1:0]   leds;
    logic [RND_W-1:0]    round;
    logic                end_FPGA;
    logic                end_User;
    logic                end_time;
    logic                match;
    logic                win;
    logic                lose;
    logic                busy;
    game_state_e         dbg_state;

    modport master (
        output start, seed, key_pulse,
        input  leds, round, end_FPGA, end_User, end_time, match, win, lose, busy, dbg_state
    );

    modport slave (
        input  start, seed, key_pulse,
        output leds, round, end_FPGA, end_User, end_time, match, win, lose, busy, dbg_state
    );

endinterface

// File: rtl/memory_game_core_lfsr16.sv
// 16-bit Fibonacci LFSR; load wins over step.
module lfsr16
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= ZERO_SEED_SUB;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/memory_game_core.sv
// Repeat-the-sequence round engine: LFSR playback, timed key checking, round growth.
module memory_game_core
    import game_pkg::*;
#(
    parameter int N_LEDS         = 4,
    parameter int MAX_ROUNDS     = 16,
    parameter int SHOW_CYCLES    = 25_000_000,
    parameter int GAP_CYCLES     = 12_500_000,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    memory_game_core_if.slave   game
);

    localparam int RND_W   = $clog2(MAX_ROUNDS + 1);
    localparam int CNT_M1  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX = (CNT_M1 > TIMEOUT_CYCLES) ? CNT_M1 : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [LFSR_W-1:0] SYM_MASK = LFSR_W'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0] LED_ONE  = N_LEDS'(1);

    game_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RND_W-1:0]  idx_q, idx_d, round_q, round_d;
    logic [15:0]       seed_q, seed_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              end_fpga_q, end_fpga_d, end_user_q, end_user_d;
    logic              end_time_q, end_time_d, match_q, match_d;
    logic              win_q, lose_q, busy_q;

    logic              lfsr_load, lfsr_step;
    logic [15:0]       load_seed, lfsr_q, lfsr_nxt;
    logic [N_LEDS-1:0] expected;

    lfsr16 u_lfsr (
        .clk  (CLOCK_50),
        .rst  (RESET),
        .load (lfsr_load),
        .seed (load_seed),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    assign expected = LED_ONE << (lfsr_q & SYM_MASK);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        round_d    = round_q;
        seed_d     = seed_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        load_seed  = seed_q;
        end_fpga_d = 1'b0;
        end_user_d = 1'b0;
        end_time_d = 1'b0;
        match_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (game.start) begin
                    seed_d    = seed_fix(game.seed);
                    load_seed = seed_fix(game.seed);
                    lfsr_load = 1'b1;
                    round_d   = RND_W'(1);
                    idx_d     = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHOW_ON;
                end
            end
            ST_SHOW_ON: begin
                if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SHOW_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if ((idx_q + RND_W'(1)) < round_q) begin
                        lfsr_step = 1'b1;
                        idx_d     = idx_q + RND_W'(1);
                        state_d   = ST_SHOW_ON;
                    end else begin
                        end_fpga_d = 1'b1;
                        lfsr_load  = 1'b1;
                        idx_d      = '0;
                        state_d    = ST_INPUT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_INPUT: begin
                if (game.key_pulse != '0) begin
                    if (game.key_pulse == expected) begin
                        match_d   = 1'b1;
                        cnt_d     = '0;
                        lfsr_step = 1'b1;
                        idx_d     = idx_q + RND_W'(1);
                        if ((idx_q + RND_W'(1)) == round_q) begin
                            end_user_d = 1'b1;
                            idx_d      = '0;
                            if (round_q == RND_W'(MAX_ROUNDS)) begin
                                state_d = ST_WIN;
                            end else begin
                                round_d   = round_q + RND_W'(1);
                                lfsr_load = 1'b1;
                                state_d   = ST_SHOW_ON;
                            end
                        end
                    end else begin
                        state_d = ST_LOSE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    end_time_d = 1'b1;
                    state_d    = ST_LOSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // LEDs are registered, so they are driven from the value the LFSR takes at this edge.
    always_comb begin
        lfsr_nxt = lfsr_load ? load_seed : (lfsr_step ? lfsr_next(lfsr_q) : lfsr_q);
        leds_d   = '0;
        if (state_d == ST_SHOW_ON) begin
            leds_d = LED_ONE << (lfsr_nxt & SYM_MASK);
        end else if (state_d == ST_WIN) begin
            leds_d = '1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            round_q    <= '0;
            seed_q     <= '0;
            leds_q     <= '0;
            end_fpga_q <= 1'b0;
            end_user_q <= 1'b0;
            end_time_q <= 1'b0;
            match_q    <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            round_q    <= round_d;
            seed_q     <= seed_d;
            leds_q     <= leds_d;
            end_fpga_q <= end_fpga_d;
            end_user_q <= end_user_d;
            end_time_q <= end_time_d;
            match_q    <= match_d;
            win_q      <= (state_d == ST_WIN);
            lose_q     <= (state_d == ST_LOSE);
            busy_q     <= (state_d == ST_SHOW_ON) || (state_d == ST_SHOW_GAP) ||
                          (state_d == ST_INPUT);
        end
    end

    assign game.leds      = leds_q;
    assign game.round     = round_q;
    assign game.end_FPGA  = end_fpga_q;
    assign game.end_User  = end_user_q;
    assign game.end_time  = end_time_q;
    assign game.match     = match_q;
    assign game.win       = win_q;
    assign game.lose      = lose_q;
    assign game.busy      = busy_q;
    assign game.dbg_state = state_q;

endmodule

// File: tb/tb_memory_game_core.sv
// Directed bench for memory_game_core with short show/gap/timeout periods.
module tb_memory_game_core;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    memory_game_core_if #(.N_LEDS(4), .MAX_ROUNDS(2)) gif ();

    memory_game_core #(
        .N_LEDS(4), .MAX_ROUNDS(2), .SHOW_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(10)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .game     (gif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_leds", 32'(gif.leds), 32'h0);
        chk("rst_round", 32'(gif.round), 32'h0);
        chk("rst_pulses", {28'h0, gif.end_FPGA, gif.end_User, gif.end_time, gif.match}, 32'h0);
        chk("rst_levels", {29'h0, gif.win, gif.lose, gif.busy}, 32'h0);
        chk("rst_state", 32'(gif.dbg_state), 32'(ST_IDLE));
    endtask

    // One played symbol: 4 cycles lit, 2 cycles dark.
    task automatic play(input logic [3:0] sym);
        for (int i = 0; i < 4; i++) begin
            chk("show_on", 32'(gif.leds), 32'(sym));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chk("show_gap", 32'(gif.leds), 32'h0);
            tick();
        end
    endtask

    task automatic start_game(input logic [15:0] s);
        gif.seed  = s;
        gif.start = 1'b1;
        tick();
        gif.start = 1'b0;
        chk("start_state", 32'(gif.dbg_state), 32'(ST_SHOW_ON));
        chk("start_round", 32'(gif.round), 32'h1);
        chk("start_busy", 32'(gif.busy), 32'h1);
    endtask

    task automatic press(input logic [3:0] k);
        gif.key_pulse = k;
        tick();
        gif.key_pulse = 4'h0;
    endtask

    task automatic chk_input_entry();
        chk("efpga_pulse", 32'(gif.end_FPGA), 32'h1);
        chk("efpga_state", 32'(gif.dbg_state), 32'(ST_INPUT));
        chk("input_leds", 32'(gif.leds), 32'h0);
    endtask

    initial begin
        gif.start     = 1'b0;
        gif.seed      = 16'h0;
        gif.key_pulse = 4'h0;
        tick();
        tick();
        chk_reset_vals();
        rst = 1'b0;
        tick();
        chk_reset_vals();

        // Round 1 playback and win path, seed 1: symbols 1 then 2.
        start_game(16'h0001);
        play(4'b0010);
        chk_input_entry();
        press(4'b0010);
        chk("r1_match", 32'(gif.match), 32'h1);
        chk("r1_end_user", 32'(gif.end_User), 32'h1);
        chk("r1_round2", 32'(gif.round), 32'h2);
        chk("r1_next_show", 32'(gif.dbg_state), 32'(ST_SHOW_ON));
        play(4'b0010);
        play(4'b0100);
        chk_input_entry();
        press(4'b0010);
        chk("r2_match_a", 32'(gif.match), 32'h1);
        chk("r2_no_end_a", 32'(gif.end_User), 32'h0);
        chk("r2_still_input", 32'(gif.dbg_state), 32'(ST_INPUT));
        press(4'b0100);
        chk("r2_match_b", 32'(gif.match), 32'h1);
        chk("r2_end_user", 32'(gif.end_User), 32'h1);
        chk("win_level", 32'(gif.win), 32'h1);
        chk("win_leds", 32'(gif.leds), 32'hF);
        chk("win_round", 32'(gif.round), 32'h2);
        chk("win_busy", 32'(gif.busy), 32'h0);
        tick();
        chk("win_hold", 32'(gif.win), 32'h1);
        chk("win_match_off", 32'(gif.match), 32'h0);

        // Wrong single key.
        start_game(16'h0001);
        play(4'b0010);
        chk_input_entry();
        press(4'b0001);
        chk("wrong_lose", 32'(gif.lose), 32'h1);
        chk("wrong_nomatch", 32'(gif.match), 32'h0);
        chk("wrong_round", 32'(gif.round), 32'h1);
        chk("wrong_leds", 32'(gif.leds), 32'h0);

        // start ignored in INPUT, then multi-hot key.
        start_game(16'h0001);
        play(4'b0010);
        chk_input_entry();
        gif.start = 1'b1;
        tick();
        gif.start = 1'b0;
        chk("ign_start_state", 32'(gif.dbg_state), 32'(ST_INPUT));
        chk("ign_start_round", 32'(gif.round), 32'h1);
        press(4'b0011);
        chk("multi_lose", 32'(gif.lose), 32'h1);
        chk("multi_nomatch", 32'(gif.match), 32'h0);

        // Timeout after 10 idle INPUT cycles.
        start_game(16'h0001);
        play(4'b0010);
        chk_input_entry();
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("to_wait_etime", 32'(gif.end_time), 32'h0);
            chk("to_wait_state", 32'(gif.dbg_state), 32'(ST_INPUT));
        end
        tick();
        chk("to_pulse", 32'(gif.end_time), 32'h1);
        chk("to_lose", 32'(gif.lose), 32'h1);
        tick();
        chk("to_single", 32'(gif.end_time), 32'h0);
        chk("to_lose_hold", 32'(gif.lose), 32'h1);

        // Correct key on the 10th INPUT cycle beats the timeout.
        start_game(16'h0001);
        play(4'b0010);
        chk_input_entry();
        for (int i = 0; i < 9; i++) tick();
        press(4'b0010);
        chk("late_match", 32'(gif.match), 32'h1);
        chk("late_no_etime", 32'(gif.end_time), 32'h0);
        chk("late_round2", 32'(gif.round), 32'h2);
        chk("late_show", 32'(gif.dbg_state), 32'(ST_SHOW_ON));

        // Reset during SHOW_ON wins over a simultaneous start.
        rst       = 1'b1;
        gif.start = 1'b1;
        tick();
        gif.start = 1'b0;
        chk_reset_vals();
        rst = 1'b0;
        tick();

        // Zero seed plays like seed 1.
        start_game(16'h0000);
        play(4'b0010);
        chk_input_entry();
        press(4'b0010);
        chk("zs_match", 32'(gif.match), 32'h1);
        play(4'b0010);
        play(4'b0100);
        chk_input_entry();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
